execute_stage_md: RTL and testbench

//  Parametrised pipeline execute stage: single-cycle ALU ops plus iterative RV32M multiply/divide.

---
 rtl/execute_pkg.sv | 52 +++++
 rtl/muldiv_iter.sv | 107 ++++++++++
 rtl/execute_stage_md.sv | 170 +++++++++++++++++
 tb/tb_execute_stage_md.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared types for the execute stage: op classes, ALU/M-extension encodings,
// multiply/divide sequencer states and operand-signedness helpers.
package execute_pkg;

    localparam int ALU_SEL_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_ALU = 2'd0,
        OP_MUL = 2'd1,
        OP_DIV = 2'd2
    } op_class_e;

    typedef enum logic [ALU_SEL_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_ITER = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    function automatic logic a_is_signed(input md_op_e op);
        return (op != MD_MULHU) && (op != MD_DIVU) && (op != MD_REMU);
    endfunction

    function automatic logic b_is_signed(input md_op_e op);
        return (op == MD_MUL) || (op == MD_MULH) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M datapath: one shift-add or restoring-subtract bit per step,
// operating on magnitudes with the sign applied combinationally at the end.
module muldiv_iter
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_start,
    input  logic                  i_step,
    input  md_op_e                i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    md_op_e          op_q;
    logic            neg_q;
    logic            neg_r;
    logic [W-1:0]    hi;
    logic [W-1:0]    lo;
    logic [W-1:0]    m;
    logic [CW-1:0]   cnt;

    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic            is_div;
    logic [W:0]      add_sum;
    logic [W:0]      rem_sh;
    logic [W:0]      diff;
    logic [2*W-1:0]  prod;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;

    always_comb begin
        a_neg   = a_is_signed(i_op) && i_a[W-1];
        b_neg   = b_is_signed(i_op) && i_b[W-1];
        a_mag   = a_neg ? -i_a : i_a;
        b_mag   = b_neg ? -i_b : i_b;
        is_div  = op_q[2];
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        rem_sh  = {hi, lo[W-1]};
        diff    = rem_sh - {1'b0, m};
    end

    assign o_done = i_step && (cnt == CW'(W - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            op_q  <= MD_MUL;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            m     <= '0;
            cnt   <= '0;
        end else if (i_flush) begin
            cnt   <= '0;
        end else if (i_start) begin
            op_q  <= i_op;
            // Divide-by-zero keeps the all-ones quotient unsigned
            neg_q <= (a_neg ^ b_neg) && (i_b != '0);
            neg_r <= a_neg;
            hi    <= '0;
            lo    <= i_op[2] ? a_mag : b_mag;
            m     <= i_op[2] ? b_mag : a_mag;
            cnt   <= '0;
        end else if (i_step) begin
            cnt <= o_done ? '0 : cnt + 1'b1;
            if (is_div) begin
                if (!diff[W]) begin
                    hi <= diff[W-1:0];
                    lo <= {lo[W-2:0], 1'b1};
                end else begin
                    hi <= rem_sh[W-1:0];
                    lo <= {lo[W-2:0], 1'b0};
                end
            end else begin
                hi <= add_sum[W:1];
                lo <= {add_sum[0], lo[W-1:1]};
            end
        end
    end

    always_comb begin
        prod     = {hi, lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -lo : lo;
        rem_fix  = neg_r ? -hi : hi;
        unique case (op_q)
            MD_MUL:                        o_result = prod_fix[W-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  o_result = prod_fix[2*W-1:W];
            MD_DIV, MD_DIVU:               o_result = quo_fix;
            default:                       o_result = rem_fix;
        endcase
    end

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage: single-cycle ALU plus iterative multiply/divide, with a
// registered output bundle behind a valid/ready handshake.
module execute_stage_md
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [1:0]               i_op_class,
    input  logic [ALU_SEL_WIDTH-1:0] i_alu_op_sel,
    input  logic [2:0]               i_md_op,
    input  logic                     i_alu_src_sel,
    input  logic [DATA_WIDTH-1:0]    i_rs1_data,
    input  logic [DATA_WIDTH-1:0]    i_rs2_data,
    input  logic [DATA_WIDTH-1:0]    i_imm,
    input  logic [PC_WIDTH-1:0]      i_pc,
    input  logic [RD_WIDTH-1:0]      i_rd_addr,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [DATA_WIDTH-1:0]    o_result,
    output logic [DATA_WIDTH-1:0]    o_store_data,
    output logic [PC_WIDTH-1:0]      o_pc_target,
    output logic                     o_zero,
    output logic [RD_WIDTH-1:0]      o_rd_addr
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);

    md_state_e          state_q;
    md_state_e          state_d;

    logic               accept;
    logic               is_md;
    logic               md_start;
    logic               md_step;
    logic               md_fix;
    logic               md_done;
    logic               alu_load;
    logic [W-1:0]       md_result;

    logic [W-1:0]       op_b;
    logic [SW-1:0]      shamt;
    logic [W-1:0]       alu_res;
    logic [PC_WIDTH-1:0] pc_sum;

    logic [W-1:0]        pend_store;
    logic [PC_WIDTH-1:0] pend_target;
    logic [RD_WIDTH-1:0] pend_rd;

    logic [W-1:0]        res_d;
    logic [W-1:0]        store_d;
    logic [PC_WIDTH-1:0] target_d;
    logic [RD_WIDTH-1:0] rd_d;

    assign o_ready = !i_reset && (state_q == MD_IDLE) &&
                     (!o_valid || i_ready) && !i_flush;
    assign accept   = i_valid && o_ready;
    assign is_md    = (i_op_class == OP_MUL) || (i_op_class == OP_DIV);
    assign md_start = accept && is_md;
    assign alu_load = accept && !is_md;
    assign pc_sum   = i_pc + PC_WIDTH'(i_imm);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= MD_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = MD_IDLE;
        end else begin
            unique case (state_q)
                MD_IDLE: if (md_start) state_d = MD_ITER;
                MD_ITER: if (md_done)  state_d = MD_FIX;
                MD_FIX:                state_d = MD_IDLE;
                default:               state_d = MD_IDLE;
            endcase
        end
    end

    always_comb begin
        md_step = (state_q == MD_ITER) && !i_flush;
        md_fix  = (state_q == MD_FIX) && !i_flush;
    end

    muldiv_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_flush  (i_flush),
        .i_start  (md_start),
        .i_step   (md_step),
        .i_op     (md_op_e'(i_md_op)),
        .i_a      (i_rs1_data),
        .i_b      (i_rs2_data),
        .o_done   (md_done),
        .o_result (md_result)
    );

    always_comb begin
        op_b  = i_alu_src_sel ? i_imm : i_rs2_data;
        shamt = op_b[SW-1:0];
        unique case (alu_op_e'(i_alu_op_sel))
            ALU_ADD:  alu_res = i_rs1_data + op_b;
            ALU_SUB:  alu_res = i_rs1_data - op_b;
            ALU_AND:  alu_res = i_rs1_data & op_b;
            ALU_OR:   alu_res = i_rs1_data | op_b;
            ALU_XOR:  alu_res = i_rs1_data ^ op_b;
            ALU_SLL:  alu_res = i_rs1_data << shamt;
            ALU_SRL:  alu_res = i_rs1_data >> shamt;
            ALU_SRA:  alu_res = W'($signed(i_rs1_data) >>> shamt);
            ALU_SLT:  alu_res = W'($signed(i_rs1_data) < $signed(op_b));
            ALU_SLTU: alu_res = W'(i_rs1_data < op_b);
            default:  alu_res = '0;
        endcase
    end

    // Sideband for an M op is captured at accept and replayed at FIX
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pend_store  <= '0;
            pend_target <= '0;
            pend_rd     <= '0;
        end else if (md_start) begin
            pend_store  <= i_rs2_data;
            pend_target <= pc_sum;
            pend_rd     <= i_rd_addr;
        end
    end

    always_comb begin
        res_d    = alu_load ? alu_res    : md_result;
        store_d  = alu_load ? i_rs2_data : pend_store;
        target_d = alu_load ? pc_sum     : pend_target;
        rd_d     = alu_load ? i_rd_addr  : pend_rd;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid      <= 1'b0;
            o_result     <= '0;
            o_store_data <= '0;
            o_pc_target  <= '0;
            o_zero       <= 1'b0;
            o_rd_addr    <= '0;
        end else begin
            if (i_flush)                  o_valid <= 1'b0;
            else if (alu_load || md_fix)  o_valid <= 1'b1;
            else if (i_ready)             o_valid <= 1'b0;

            if (alu_load || md_fix) begin
                o_result     <= res_d;
                o_store_data <= store_d;
                o_pc_target  <= target_d;
                o_zero       <= (res_d == '0);
                o_rd_addr    <= rd_d;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed bench for execute_stage_md: ALU ops, M-extension latency and
// corner cases, backpressure, flush and mid-operation reset.
module tb_execute_stage_md;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid;
    logic        o_ready;
    logic [1:0]  op_class;
    logic [3:0]  alu_op;
    logic [2:0]  md_op;
    logic        src_sel;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        o_valid;
    logic        rdy;
    logic [31:0] o_result;
    logic [31:0] o_store;
    logic [31:0] o_target;
    logic        o_zero;
    logic [4:0]  o_rd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_stage_md dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_flush       (flush),
        .i_valid       (valid),
        .o_ready       (o_ready),
        .i_op_class    (op_class),
        .i_alu_op_sel  (alu_op),
        .i_md_op       (md_op),
        .i_alu_src_sel (src_sel),
        .i_rs1_data    (rs1),
        .i_rs2_data    (rs2),
        .i_imm         (imm),
        .i_pc          (pc),
        .i_rd_addr     (rd),
        .o_valid       (o_valid),
        .i_ready       (rdy),
        .o_result      (o_result),
        .o_store_data  (o_store),
        .o_pc_target   (o_target),
        .o_zero        (o_zero),
        .o_rd_addr     (o_rd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic src,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] im);
        valid    = 1'b1;
        op_class = 2'd0;
        alu_op   = op;
        src_sel  = src;
        rs1      = a;
        rs2      = b;
        imm      = im;
    endtask

    // Issues an M op and waits for its result; expects exactly 33 edges
    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int n;
        int busy_ok;
        valid    = 1'b1;
        op_class = op[2] ? 2'd2 : 2'd1;
        md_op    = op;
        src_sel  = 1'b1;
        rs1      = a;
        rs2      = b;
        imm      = 32'h10;
        pc       = 32'h2000;
        rd       = 5'd9;
        rdy      = 1'b1;
        check({tag, "_ready_in"}, 32'(o_ready), 32'd1);
        step();
        valid   = 1'b0;
        n       = 0;
        busy_ok = 1;
        while (!o_valid && n < 40) begin
            if (o_ready) busy_ok = 0;
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd33);
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_result"}, o_result, exp);
        check({tag, "_target"}, o_target, 32'h2010);
        check({tag, "_rd"}, 32'(o_rd), 32'd9);
        check({tag, "_store"}, o_store, b);
        step();
    endtask

    initial begin
        logic [3:0]  v_op  [10];
        logic [31:0] v_a   [10];
        logic [31:0] v_b   [10];
        logic [31:0] v_exp [10];
        int          seen;

        rst = 1'b1; flush = 1'b0; valid = 1'b0; op_class = 2'd0;
        alu_op = 4'd0; md_op = 3'd0; src_sel = 1'b0;
        rs1 = '0; rs2 = '0; imm = '0; pc = '0; rd = '0; rdy = 1'b0;
        step();
        step();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_target", o_target, 32'd0);
        check("rst_rd", 32'(o_rd), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(o_ready), 32'd1);

        // 1: ADD with immediate
        step();
        drive_alu(4'd0, 1'b1, 32'd5, 32'hABCD, 32'hFFFF_FFFD);
        pc = 32'h100;
        rd = 5'd7;
        step();
        valid = 1'b0;
        check("add_valid", 32'(o_valid), 32'd1);
        check("add_result", o_result, 32'd2);
        check("add_zero", 32'(o_zero), 32'd0);
        check("add_target", o_target, 32'h0000_00FD);
        check("add_store", o_store, 32'hABCD);
        check("add_rd", 32'(o_rd), 32'd7);
        rdy = 1'b1;
        step();
        check("add_drain", 32'(o_valid), 32'd0);

        // 2: M ops, including divide corner cases
        run_md("mulh", 3'd1, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF);
        run_md("mul", 3'd0, 32'd6, 32'hFFFF_FFFD, 32'hFFFF_FFEE);
        run_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE);
        run_md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF);
        run_md("div0", 3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_md("divn0", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run_md("rem0", 3'd6, 32'd7, 32'd0, 32'd7);
        run_md("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000);
        run_md("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_md("divu", 3'd5, 32'd100, 32'd7, 32'd14);
        run_md("remneg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        check("md_drain", 32'(o_valid), 32'd0);

        // 4: SUB result held under backpressure
        rdy = 1'b0;
        drive_alu(4'd1, 1'b0, 32'd9, 32'd9, 32'd0);
        step();
        drive_alu(4'd0, 1'b1, 32'd1, 32'd0, 32'd1);
        check("sub_result", o_result, 32'd0);
        check("sub_zero", 32'(o_zero), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("bp_ready", 32'(o_ready), 32'd0);
            step();
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_result", o_result, 32'd0);
            check("bp_zero", 32'(o_zero), 32'd1);
        end
        rdy = 1'b1;
        #1;
        check("bp_release", 32'(o_ready), 32'd1);
        step();
        valid = 1'b0;
        check("bp_next_valid", 32'(o_valid), 32'd1);
        check("bp_next_result", o_result, 32'd2);
        check("bp_next_zero", 32'(o_zero), 32'd0);
        step();
        check("bp_drain", 32'(o_valid), 32'd0);

        // 5: flush during DIVU
        valid = 1'b1; op_class = 2'd2; md_op = 3'd5;
        rs1 = 32'd100; rs2 = 32'd7;
        step();
        valid = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        #1;
        check("fl_ready", 32'(o_ready), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("fl_idle_ready", 32'(o_ready), 32'd1);
        check("fl_idle_valid", 32'(o_valid), 32'd0);
        drive_alu(4'd0, 1'b0, 32'd3, 32'd4, 32'd0);
        step();
        valid = 1'b0;
        check("fl_add_valid", 32'(o_valid), 32'd1);
        check("fl_add_result", o_result, 32'd7);
        seen = 0;
        repeat (40) begin
            step();
            if (o_valid) seen++;
        end
        check("fl_no_ghost", 32'(seen), 32'd0);

        // 6: back-to-back ALU ops
        v_op[0] = 4'd2;  v_a[0] = 32'hFF00_FF00; v_b[0] = 32'h0F0F_0F0F;
        v_exp[0] = 32'h0F00_0F00;
        v_op[1] = 4'd3;  v_a[1] = 32'hFF00_FF00; v_b[1] = 32'h0F0F_0F0F;
        v_exp[1] = 32'hFF0F_FF0F;
        v_op[2] = 4'd4;  v_a[2] = 32'hFF00_FF00; v_b[2] = 32'h0F0F_0F0F;
        v_exp[2] = 32'hF00F_F00F;
        v_op[3] = 4'd5;  v_a[3] = 32'd1;         v_b[3] = 32'h24;
        v_exp[3] = 32'h10;
        v_op[4] = 4'd6;  v_a[4] = 32'h8000_0000; v_b[4] = 32'h3F;
        v_exp[4] = 32'd1;
        v_op[5] = 4'd7;  v_a[5] = 32'h8000_0000; v_b[5] = 32'd4;
        v_exp[5] = 32'hF800_0000;
        v_op[6] = 4'd8;  v_a[6] = 32'hFFFF_FFFF; v_b[6] = 32'd1;
        v_exp[6] = 32'd1;
        v_op[7] = 4'd9;  v_a[7] = 32'hFFFF_FFFF; v_b[7] = 32'd1;
        v_exp[7] = 32'd0;
        v_op[8] = 4'd12; v_a[8] = 32'h1234;      v_b[8] = 32'h5678;
        v_exp[8] = 32'd0;
        v_op[9] = 4'd1;  v_a[9] = 32'd3;         v_b[9] = 32'd5;
        v_exp[9] = 32'hFFFF_FFFE;
        rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_alu(v_op[i], 1'b0, v_a[i], v_b[i], 32'd0);
            check("b2b_ready", 32'(o_ready), 32'd1);
            step();
            check("b2b_valid", 32'(o_valid), 32'd1);
            check("b2b_result", o_result, v_exp[i]);
            check("b2b_zero", 32'(o_zero), 32'(v_exp[i] == 32'd0));
        end
        valid = 1'b0;
        step();

        // Reset mid-multiply discards the partial result
        valid = 1'b1; op_class = 2'd1; md_op = 3'd0;
        rs1 = 32'd3; rs2 = 32'd5;
        step();
        valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("mrst_ready", 32'(o_ready), 32'd0);
        check("mrst_valid", 32'(o_valid), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("mrst_rel_ready", 32'(o_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            step();
            if (o_valid) seen++;
        end
        check("mrst_no_ghost", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
